pam_symbol_scheduler: RTL and testbench
=======================================

Name: pam_symbol_scheduler

Overview:
Sequences 2-bit symbols into the pam_mixer `data_in` port, which is driven from the sin_cos sample clock. Buffers host symbols in a small FIFO with a valid/ready handshake. Frames each burst as preamble, then data, then guard, and holds every symbol for exactly SYM_LEN sample clocks. Drives idle (2'b00) between frames.

Parameters:
SYM_LEN, 1000, sample clocks per symbol (must be ≥2)
CNT_W, 10, symbol counter width (2^CNT_W ≥ SYM_LEN)
PREAMBLE_LEN, 4, preamble symbols per frame (≥1)
GUARD_LEN, 2, trailing idle symbols per frame (≥1)
FIFO_AW, 3, FIFO address width; depth = 2^FIFO_AW

Ports:
clk  in  1  sample clock, same clock as sin_cos/pam_mixer; all logic on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  host symbol valid
in_data  in  2  host symbol
in_ready  out  1  FIFO can accept; equals ~full
frame_start  in  1  single-cycle start request
frame_len  in  8  data symbols in the frame; sampled with frame_start
data_out  out  2  symbol to pam_mixer data_in
sym_strobe  out  1  high on the last clock of each symbol while a frame is active
tx_active  out  1  high in PREAMBLE, DATA, GUARD
state_out  out  2  IDLE=0, PREAMBLE=1, DATA=2, GUARD=3
fifo_level  out  FIFO_AW+1  current FIFO occupancy
underrun  out  1  one-cycle pulse when a data slot finds the FIFO empty

Behaviour:
- Reset values (async, immediate): state IDLE, data_out 0, sym_cnt 0, symbol index 0, FIFO pointers 0, fifo_level 0, in_ready 1, sym_strobe 0, tx_active 0, underrun 0.
- FIFO:
  - Write on in_valid & in_ready.
  - Pop only at DATA symbol boundaries.
  - Simultaneous write and pop leaves the level unchanged.
  - No bypass: a write and a pop on the same cycle with an empty FIFO is an underrun; the written symbol stays queued.
  - Full: in_ready=0 and in_valid is ignored. The FIFO is never overwritten.
- Symbol counter: sym_cnt runs 0..SYM_LEN-1 while tx_active, then wraps to 0. It is held at 0 in IDLE. Boundary = sym_cnt==SYM_LEN-1, and sym_strobe is asserted on that cycle (combinational from state and count).
- All outputs except sym_strobe are registered. A new data_out value appears on the clock after the boundary.
- IDLE:
  - data_out=0.
  - frame_start=1 with frame_len≠0: latch frame_len, go to PREAMBLE, data_out=preamble[0] on the next clock.
  - frame_start with frame_len=0 is ignored.
  - frame_start while tx_active is ignored.
- PREAMBLE:
  - Symbol k = 2'b00 for even k, 2'b11 for odd k.
  - After PREAMBLE_LEN symbols, go to DATA and load the first data symbol at that boundary.
- DATA:
  - At each slot start, pop the FIFO head into data_out.
  - If the FIFO is empty: data_out=0, pulse underrun for 1 cycle. The slot still counts toward frame_len.
  - After frame_len slots, go to GUARD.
- GUARD: data_out=0 for GUARD_LEN symbols, then IDLE. sym_cnt is cleared on entry to IDLE.
- Frame duration: (PREAMBLE_LEN+frame_len+GUARD_LEN)×SYM_LEN clocks, from the clock after frame_start to the first IDLE cycle.
- Reset mid-frame: abort immediately, flush the FIFO, return to IDLE with reset values.
- Host writes are accepted in every state, including during a frame.

Optional Feature:
PAM_GRAY_EN
- Defined: DATA-state symbols are Gray-mapped before data_out: 00→00, 01→01, 10→11, 11→10. Preamble, guard, idle and underrun fill are unaffected.
- Undefined: data symbols pass through unchanged.

Test Plan:
- Reset: assert rst mid-cycle → all outputs at reset values immediately; in_ready=1, fifo_level=0.
- Basic frame (SYM_LEN=4, PREAMBLE_LEN=4, GUARD_LEN=2):
  - Stimulus: preload 01,10,11; pulse frame_start with frame_len=3.
  - Required data_out sequence, each symbol held 4 clocks: 00,11,00,11,01,10,11,00,00.
  - sym_strobe fires 9 times; tx_active is high for 36 clocks; then IDLE.
  - With PAM_GRAY_EN: data symbols become 01,11,10.
- FIFO full: write 9 symbols back-to-back with depth 8 → in_ready drops after the 8th; the 9th is held off; fifo_level=8.
- Underrun: preload 1 symbol (10), frame_len=3 → data symbols 10,00,00; underrun pulses twice, each for 1 cycle at the boundaries; frame length is unchanged.
- Ignored starts:
  - frame_start with frame_len=0 → stays IDLE.
  - frame_start during DATA → no effect on state or count.
- Reset mid-frame: assert rst during DATA with fifo_level=3 → IDLE, fifo_level=0, data_out=0; a subsequent frame runs normally.

Source files
------------

// File: rtl/pam_symbol_scheduler.sv
// PAM symbol scheduler: host FIFO -> framed symbol stream (preamble, data, guard), each symbol held SYM_LEN clocks.
// Optional macro PAM_GRAY_EN: Gray-map DATA-state symbols before they reach data_out.
module pam_symbol_scheduler #(
  parameter int SYM_LEN      = 1000,
  parameter int CNT_W        = 10,
  parameter int PREAMBLE_LEN = 4,
  parameter int GUARD_LEN    = 2,
  parameter int FIFO_AW      = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [1:0]         in_data,
  output logic               in_ready,
  input  logic               frame_start,
  input  logic [7:0]         frame_len,
  output logic [1:0]         data_out,
  output logic               sym_strobe,
  output logic               tx_active,
  output logic [1:0]         state_out,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               underrun
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_GUARD    = 2'd3
  } state_t;

  localparam int                 DEPTH      = 1 << FIFO_AW;
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SYM_LEN - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [7:0]         PRE_LAST   = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]         GRD_LAST   = 8'(GUARD_LEN - 1);
  localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LEVEL_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

  state_t             state, state_next;
  logic [CNT_W-1:0]   sym_cnt, cnt_next;
  logic [7:0]         sym_idx, idx_next;
  logic [7:0]         len_q, len_next;
  logic [1:0]         data_q, data_next;
  logic               tx_active_q, underrun_q, underrun_next, in_ready_q;
  logic [FIFO_AW:0]   level, level_next;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [1:0]         mem [DEPTH];
  logic               boundary, push, pop, pop_req;

  function automatic logic [1:0] map_sym(input logic [1:0] s);
`ifdef PAM_GRAY_EN
    return {s[1], s[1] ^ s[0]};
`else
    return s;
`endif
  endfunction

  // Handshake: a symbol transfers on any clock where in_valid && in_ready; in_ready drops only when the FIFO is full.
  assign push     = in_valid && in_ready_q;
  assign boundary = (state != S_IDLE) && (sym_cnt == CNT_LAST);
  assign pop      = pop_req && (level != '0);

  always_comb begin
    state_next    = state;
    cnt_next      = sym_cnt;
    idx_next      = sym_idx;
    len_next      = len_q;
    data_next     = data_q;
    underrun_next = 1'b0;
    pop_req       = 1'b0;
    if (state != S_IDLE) cnt_next = boundary ? '0 : sym_cnt + CNT_ONE;
    case (state)
      S_IDLE: begin
        data_next = 2'b00;
        cnt_next  = '0;
        if (frame_start && (frame_len != 8'd0)) begin
          state_next = S_PREAMBLE;
          len_next   = frame_len;
          idx_next   = 8'd0;
          data_next  = 2'b00;
        end
      end
      S_PREAMBLE: begin
        if (boundary) begin
          if (sym_idx == PRE_LAST) begin
            state_next = S_DATA;
            idx_next   = 8'd0;
            pop_req    = 1'b1;
          end else begin
            idx_next  = sym_idx + 8'd1;
            // next index is odd exactly when the current one is even
            data_next = sym_idx[0] ? 2'b00 : 2'b11;
          end
        end
      end
      S_DATA: begin
        if (boundary) begin
          if (sym_idx == len_q - 8'd1) begin
            state_next = S_GUARD;
            idx_next   = 8'd0;
            data_next  = 2'b00;
          end else begin
            idx_next = sym_idx + 8'd1;
            pop_req  = 1'b1;
          end
        end
      end
      S_GUARD: begin
        if (boundary) begin
          data_next = 2'b00;
          if (sym_idx == GRD_LAST) begin
            state_next = S_IDLE;
            idx_next   = 8'd0;
            cnt_next   = '0;
          end else begin
            idx_next = sym_idx + 8'd1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
    // An empty FIFO at a data slot still consumes the slot, filled with idle.
    if (pop_req) begin
      if (level != '0) begin
        data_next = map_sym(mem[rd_ptr]);
      end else begin
        data_next     = 2'b00;
        underrun_next = 1'b1;
      end
    end
  end

  always_comb begin
    level_next = level;
    if (push && !pop)      level_next = level + LEVEL_ONE;
    else if (!push && pop) level_next = level - LEVEL_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      sym_cnt     <= '0;
      sym_idx     <= 8'd0;
      len_q       <= 8'd0;
      data_q      <= 2'b00;
      tx_active_q <= 1'b0;
      underrun_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      level       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      state       <= state_next;
      sym_cnt     <= cnt_next;
      sym_idx     <= idx_next;
      len_q       <= len_next;
      data_q      <= data_next;
      tx_active_q <= (state_next != S_IDLE);
      underrun_q  <= underrun_next;
      in_ready_q  <= (level_next != LEVEL_FULL);
      level       <= level_next;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  assign in_ready   = in_ready_q;
  assign data_out   = data_q;
  assign sym_strobe = boundary;
  assign tx_active  = tx_active_q;
  assign state_out  = state;
  assign fifo_level = level;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_pam_symbol_scheduler.sv
// Directed bench for pam_symbol_scheduler with SYM_LEN=4, PREAMBLE_LEN=4, GUARD_LEN=2, FIFO depth 8.
module tb_pam_symbol_scheduler;

  localparam int MAXC = 120;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_data = 2'b00;
  logic       in_ready;
  logic       frame_start = 1'b0;
  logic [7:0] frame_len = 8'd0;
  logic [1:0] data_out;
  logic       sym_strobe;
  logic       tx_active;
  logic [1:0] state_out;
  logic [3:0] fifo_level;
  logic       underrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] cap_data  [MAXC];
  logic       cap_strobe[MAXC];
  logic       cap_under [MAXC];
  logic [1:0] cap_state [MAXC];
  int         cap_n;

  pam_symbol_scheduler #(
    .SYM_LEN(4), .CNT_W(3), .PREAMBLE_LEN(4), .GUARD_LEN(2), .FIFO_AW(3)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .frame_start(frame_start), .frame_len(frame_len), .data_out(data_out),
    .sym_strobe(sym_strobe), .tx_active(tx_active), .state_out(state_out),
    .fifo_level(fifo_level), .underrun(underrun)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_map(input logic [1:0] s);
`ifdef PAM_GRAY_EN
    case (s)
      2'b10:   return 2'b11;
      2'b11:   return 2'b10;
      default: return s;
    endcase
`else
    return s;
`endif
  endfunction

  // driver tasks
  task automatic write_sym(input logic [1:0] s);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = s;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] len);
    @(negedge clk);
    frame_start = 1'b1;
    frame_len   = len;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  // records one cycle per negedge while tx_active; optionally pulses a stray frame_start
  task automatic capture_frame(input int inject_at);
    cap_n = 0;
    while (cap_n < MAXC && tx_active === 1'b1) begin
      cap_data[cap_n]   = data_out;
      cap_strobe[cap_n] = sym_strobe;
      cap_under[cap_n]  = underrun;
      cap_state[cap_n]  = state_out;
      if (cap_n == inject_at) begin
        frame_start = 1'b1;
        frame_len   = 8'd5;
      end else begin
        frame_start = 1'b0;
      end
      cap_n++;
      @(negedge clk);
    end
    frame_start = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (state_out !== 2'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_out); end
    n_checks++; if (data_out !== 2'b00) begin n_fail++; $display("FAIL reset_data got=%b exp=00", data_out); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    n_checks++; if (sym_strobe !== 1'b0 || tx_active !== 1'b0 || underrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got=%b%b%b exp=000", sym_strobe, tx_active, underrun);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_frame;
    logic [1:0] exp_sym [9];
    int strobes, k;
    logic [1:0] exp_st;
    exp_sym[0] = 2'b00; exp_sym[1] = 2'b11; exp_sym[2] = 2'b00; exp_sym[3] = 2'b11;
    exp_sym[4] = exp_map(2'b01); exp_sym[5] = exp_map(2'b10); exp_sym[6] = exp_map(2'b11);
    exp_sym[7] = 2'b00; exp_sym[8] = 2'b00;
    write_sym(2'b01); write_sym(2'b10); write_sym(2'b11);
    n_checks++; if (fifo_level !== 4'd3) begin n_fail++; $display("FAIL basic_preload_level got=%0d exp=3", fifo_level); end
    start_frame(8'd3);
    capture_frame(-1);
    n_checks++; if (cap_n != 36) begin n_fail++; $display("FAIL basic_active_cycles got=%0d exp=36", cap_n); end
    strobes = 0;
    for (int i = 0; i < 36 && i < cap_n; i++) begin
      k = i / 4;
      exp_st = (k < 4) ? 2'd1 : (k < 7) ? 2'd2 : 2'd3;
      if (cap_strobe[i] === 1'b1) strobes++;
      n_checks++; if (cap_data[i] !== exp_sym[k]) begin n_fail++; $display("FAIL basic_data cyc=%0d got=%b exp=%b", i, cap_data[i], exp_sym[k]); end
      n_checks++; if (cap_strobe[i] !== (i % 4 == 3)) begin n_fail++; $display("FAIL basic_strobe cyc=%0d got=%b exp=%b", i, cap_strobe[i], (i % 4 == 3)); end
      n_checks++; if (cap_state[i] !== exp_st) begin n_fail++; $display("FAIL basic_state cyc=%0d got=%0d exp=%0d", i, cap_state[i], exp_st); end
      n_checks++; if (cap_under[i] !== 1'b0) begin n_fail++; $display("FAIL basic_underrun cyc=%0d got=%b exp=0", i, cap_under[i]); end
    end
    n_checks++; if (strobes != 9) begin n_fail++; $display("FAIL basic_strobe_count got=%0d exp=9", strobes); end
    n_checks++; if (state_out !== 2'd0 || data_out !== 2'b00 || sym_strobe !== 1'b0) begin
      n_fail++; $display("FAIL basic_post_idle got=st%0d d%b s%b exp=st0 d00 s0", state_out, data_out, sym_strobe);
    end
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL basic_post_level got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_fifo_full;
    logic [1:0] d;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      n_checks++; if (in_ready !== (j < 8)) begin n_fail++; $display("FAIL full_ready wr=%0d got=%b exp=%b", j, in_ready, (j < 8)); end
      in_valid = 1'b1;
      d = 2'(j);
      in_data = d;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL full_level got=%0d exp=8", fifo_level); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_held got=%b exp=0", in_ready); end
    start_frame(8'd8);
    capture_frame(-1);
    n_checks++; if (cap_n != 56) begin n_fail++; $display("FAIL full_active_cycles got=%0d exp=56", cap_n); end
    for (int s = 0; s < 8; s++) begin
      d = 2'(s);
      if ((16 + 4 * s) < cap_n) begin
        n_checks++; if (cap_data[16 + 4 * s] !== exp_map(d)) begin
          n_fail++; $display("FAIL full_drain slot=%0d got=%b exp=%b", s, cap_data[16 + 4 * s], exp_map(d));
        end
      end
    end
    n_checks++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL full_post_level got=%0d exp=0", fifo_level); end
  endtask

  task automatic test_underrun;
    logic [1:0] exp_sym [9];
    int pulses;
    logic exp_u;
    exp_sym[0] = 2'b00; exp_sym[1] = 2'b11; exp_sym[2] = 2'b00; exp_sym[3] = 2'b11;
    exp_sym[4] = exp_map(2'b10); exp_sym[5] = 2'b00; exp_sym[6] = 2'b00;
    exp_sym[7] = 2'b00; exp_sym[8] = 2'b00;
    write_sym(2'b10);
    start_frame(8'd3);
    capture_frame(-1);
    n_checks++; if (cap_n != 36) begin n_fail++; $display("FAIL under_active_cycles got=%0d exp=36", cap_n); end
    pulses = 0;
    for (int i = 0; i < 36 && i < cap_n; i++) begin
      exp_u = (i == 20) || (i == 24);
      if (cap_under[i] === 1'b1) pulses++;
      n_checks++; if (cap_data[i] !== exp_sym[i / 4]) begin n_fail++; $display("FAIL under_data cyc=%0d got=%b exp=%b", i, cap_data[i], exp_sym[i / 4]); end
      n_checks++; if (cap_under[i] !== exp_u) begin n_fail++; $display("FAIL under_pulse cyc=%0d got=%b exp=%b", i, cap_under[i], exp_u); end
    end
    n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL under_count got=%0d exp=2", pulses); end
  endtask

  task automatic test_ignored_starts;
    @(negedge clk);
    frame_start = 1'b1;
    frame_len   = 8'd0;
    @(negedge clk);
    frame_start = 1'b0;
    n_checks++; if (state_out !== 2'd0 || tx_active !== 1'b0) begin
      n_fail++; $display("FAIL zero_len_start got=st%0d a%b exp=st0 a0", state_out, tx_active);
    end
    @(negedge clk);
    n_checks++; if (state_out !== 2'd0) begin n_fail++; $display("FAIL zero_len_hold got=%0d exp=0", state_out); end
    write_sym(2'b01); write_sym(2'b10); write_sym(2'b11);
    start_frame(8'd3);
    capture_frame(18);
    n_checks++; if (cap_n != 36) begin n_fail++; $display("FAIL busy_start_cycles got=%0d exp=36", cap_n); end
    for (int i = 16; i < 28 && i < cap_n; i++) begin
      n_checks++; if (cap_state[i] !== 2'd2) begin n_fail++; $display("FAIL busy_start_state cyc=%0d got=%0d exp=2", i, cap_state[i]); end
      n_checks++; if (cap_strobe[i] !== (i % 4 == 3)) begin n_fail++; $display("FAIL busy_start_strobe cyc=%0d got=%b exp=%b", i, cap_strobe[i], (i % 4 == 3)); end
    end
    if (cap_n > 24) begin
      n_checks++; if (cap_data[24] !== exp_map(2'b11)) begin n_fail++; $display("FAIL busy_start_data got=%b exp=%b", cap_data[24], exp_map(2'b11)); end
    end
    n_checks++; if (state_out !== 2'd0) begin n_fail++; $display("FAIL busy_start_post got=%0d exp=0", state_out); end
  endtask

  task automatic test_reset_mid_frame;
    int k;
    write_sym(2'b11); write_sym(2'b01); write_sym(2'b10); write_sym(2'b00);
    start_frame(8'd4);
    k = 0;
    while (state_out !== 2'd2 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_checks++; if (state_out !== 2'd2) begin n_fail++; $display("FAIL midrst_reach_data got=%0d exp=2", state_out); end
    n_checks++; if (fifo_level !== 4'd3) begin n_fail++; $display("FAIL midrst_level_before got=%0d exp=3", fifo_level); end
    n_checks++; if (data_out !== exp_map(2'b11)) begin n_fail++; $display("FAIL midrst_data_before got=%b exp=%b", data_out, exp_map(2'b11)); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (state_out !== 2'd0 || tx_active !== 1'b0) begin n_fail++; $display("FAIL midrst_state got=st%0d a%b exp=st0 a0", state_out, tx_active); end
    n_checks++; if (fifo_level !== 4'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_fifo got=lvl%0d rdy%b exp=lvl0 rdy1", fifo_level, in_ready); end
    n_checks++; if (data_out !== 2'b00 || sym_strobe !== 1'b0 || underrun !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs got=d%b s%b u%b exp=d00 s0 u0", data_out, sym_strobe, underrun);
    end
    @(negedge clk);
    rst = 1'b0;
    test_basic_frame();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_fifo_full();
    test_underrun();
    test_ignored_starts();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
